// File: rtl/disp_mux_seq.sv
// disp_mux_seq: registered 7-seg source mux with score scroll/blink; blink built only with DISP_MUX_BLINK_EN
module disp_mux_seq #(
    parameter int N_DIG = 6,
    parameter int SEG_W = 8,
    parameter logic [SEG_W-1:0] DASH_PAT = 8'h3F,
    parameter logic [SEG_W-1:0] BLANK_PAT = 8'hFF,
    parameter int BLINK_TICKS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   tick,
    input  logic [2:0]             mode,
    input  logic [SEG_W-1:0]       mode_disp,
    input  logic [N_DIG*SEG_W-1:0] scram,
    input  logic [N_DIG*SEG_W-1:0] score,
    output logic [N_DIG*SEG_W-1:0] disp,
    output logic [2:0]             mode_q,
    output logic                   frame_start
);
    localparam int RING = 2*N_DIG;
    localparam int PW = $clog2(RING);
    localparam int H = N_DIG/2;
    logic [PW-1:0] pos;
    logic wrap_q, chg, adv, blank;
    logic [N_DIG*SEG_W-1:0] nxt;
    logic [RING*SEG_W-1:0] ring;
    assign chg = mode != mode_q;
    assign adv = tick && !chg && mode_q == 3'd5;
    assign ring = {{N_DIG{BLANK_PAT}}, score};
`ifdef DISP_MUX_BLINK_EN
    localparam int BW = $clog2(BLINK_TICKS+1);
    logic [BW-1:0] bcnt;
    logic phase;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt <= '0;
            phase <= 1'b1;
        end else if (chg) begin
            bcnt <= '0;
            phase <= 1'b1;
        end else if (tick && mode_q == 3'd6) begin
            bcnt <= (bcnt == BW'(BLINK_TICKS-1)) ? '0 : bcnt + 1'b1;
            phase <= (bcnt == BW'(BLINK_TICKS-1)) ? ~phase : phase;
        end
    end
    assign blank = mode_q == 3'd6 && !phase;
`else
    assign blank = 1'b0;
`endif
    always_comb begin
        nxt = {N_DIG{DASH_PAT}};
        case (mode_q)
            3'd1: nxt[SEG_W-1:0] = mode_disp;
            3'd2: nxt = scram;
            3'd3, 3'd6: begin
                nxt[(H-1)*SEG_W +: SEG_W] = blank ? BLANK_PAT : score[0 +: SEG_W];
                nxt[H*SEG_W +: SEG_W] = blank ? BLANK_PAT : score[SEG_W +: SEG_W];
            end
            3'd4: for (int i = 1; i < N_DIG-1; i++) nxt[i*SEG_W +: SEG_W] = score[(i+1)*SEG_W +: SEG_W];
            3'd5: for (int i = 0; i < N_DIG; i++) nxt[i*SEG_W +: SEG_W] = ring[((i + int'(pos)) % RING)*SEG_W +: SEG_W];
            default: ;
        endcase
    end
    // frame_start is delayed one cycle so it lines up with the disp showing pos 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= '0;
            pos <= '0;
            wrap_q <= 1'b0;
            frame_start <= 1'b0;
            disp <= {N_DIG{DASH_PAT}};
        end else begin
            mode_q <= mode;
            pos <= chg ? '0 : adv ? ((pos == PW'(RING-1)) ? '0 : pos + 1'b1) : pos;
            wrap_q <= adv && pos == PW'(RING-1);
            frame_start <= wrap_q;
            disp <= nxt;
        end
    end
endmodule

// File: doc/disp_mux_seq.md
# disp_mux_seq

Registered, parametrised seven-segment display multiplexer for the game front panel. Selects which source drives an `N_DIG`-digit display (mode indicator, scrambled word, short or long score), and adds tick-driven behaviour: a scrolling marquee of the score and a blinking score. It sits between the game controller (which drives `mode`) and the segment drivers, with a free-running prescaler providing `tick`.

## Interface
Parameters:
- `N_DIG`, 6: number of digits; even, at least 4.
- `SEG_W`, 8: bits per digit pattern.
- `DASH_PAT`, 8'h3F: active-low dash pattern.
- `BLANK_PAT`, 8'hFF: active-low all-off pattern.
- `BLINK_TICKS`, 4: ticks per blink half-period; at least 1.

Ports (clock and reset first):
- `clk` in 1: system clock.
- `rst_n` in 1: reset; one clock, asynchronous, active-low.
- `tick` in 1: one-cycle strobe from the prescaler; advances scroll and blink.
- `mode` in 3: display mode select.
- `mode_disp` in SEG_W: pattern for the mode digit.
- `scram` in N_DIG*SEG_W: scrambled-word digits; digit i is at [i*SEG_W +: SEG_W].
- `score` in N_DIG*SEG_W: score digits, same packing.
- `disp` out N_DIG*SEG_W: registered display digits, same packing.
- `mode_q` out 3: the mode currently being displayed.
- `frame_start` out 1: one-cycle pulse when the scroll position wraps to 0.

## Operation
- `mode` is registered into `mode_q` every cycle. `disp` is computed from `mode_q` and the live source buses, then registered.
- Modes. In every mode, digits not listed show DASH_PAT.
  - 0: all DASH_PAT.
  - 1: digit 0 = `mode_disp`.
  - 2: digit i = scram digit i.
  - 3 (score short): digit N_DIG/2-1 = score 0, digit N_DIG/2 = score 1.
  - 4 (score long): digits 1..N_DIG-2 = score digits 2..N_DIG-1.
  - 5 (scroll): uses a virtual ring of 2*N_DIG entries. Entries 0..N_DIG-1 are score digits; entries N_DIG..2N_DIG-1 are BLANK_PAT. Digit i = ring[(i+pos) mod 2*N_DIG].
  - 6 (blink): like mode 3, but the two score digits show BLANK_PAT while `phase` = 0.
  - 7: all DASH_PAT.
- Scroll position `pos`, range 0..2*N_DIG-1:
  - Advances by 1 on each `tick` while `mode_q` = 5.
  - Wraps from 2*N_DIG-1 to 0. The wrap raises `frame_start` for one cycle, concurrent with the `disp` update.
- Blink state:
  - `bcnt` counts ticks 0..BLINK_TICKS-1 while `mode_q` = 6.
  - On the tick where `bcnt` wraps, `phase` toggles.
- Mode change: any cycle where `mode` differs from `mode_q` sets `pos`=0, `bcnt`=0 and `phase`=1, overriding a simultaneous `tick`.
- In modes other than 5 and 6, `pos`, `bcnt` and `phase` hold their values.

## Timing
- Reset values:
  - `disp` = all DASH_PAT.
  - `mode_q` = 0.
  - `frame_start` = 0.
  - `pos` = 0, `bcnt` = 0, `phase` = 1.
- Latency:
  - `mode` to `mode_q`: 1 cycle.
  - `mode` to `disp`: 2 cycles.
  - Source data to `disp`: 1 cycle.
  - `tick` to the `disp` change: 1 cycle after the `pos`/`phase` update, so 2 cycles from `tick`.
- Source buses are sampled every cycle; a source change is visible even when `mode` is static.
- Assertion of `rst_n` mid-scroll or mid-blink returns immediately to the reset values. No `frame_start` pulse is generated by reset.
- `tick` held high for consecutive cycles advances once per cycle.

## Configuration
- `DISP_MUX_BLINK_EN` defined: mode 6 blinks as described; `bcnt` and `phase` are implemented.
- Not defined: `bcnt` and `phase` are removed. Mode 6 displays identically to mode 3 (steady), and `tick` has no effect in mode 6.

## Test plan
With N_DIG=6, BLINK_TICKS=4:
- Reset, then release with mode=0 -> `disp` = six 8'h3F, `mode_q`=0, `frame_start`=0.
- mode=3, score digit0=8'hC0, digit1=8'hF9 -> two cycles later `disp` digits 2,3 = C0,F9; all others 3F.
- mode=5 with score digits 0..5 = 8'h00..8'h05, then 12 ticks -> after tick k, digit0 = score[k] for k<6 and 8'hFF for 6<=k<12. On the 12th tick `pos` wraps to 0 and `frame_start` pulses exactly once.
- mode=6, macro defined -> digits 2,3 show score for 4 ticks, then FF for 4 ticks, then score again. Macro undefined -> steady score.
- Mode switch 5->4->5 mid-scroll (pos=7), with a `tick` in the switch cycle -> `pos` restarts at 0; no `frame_start` pulse.
- Assert `rst_n` low at pos=3 -> `disp` all 3F on the next edge and `pos`=0.
